// File: rtl/uart_pkg.sv
// Shared types, default constants and helpers for the 16x oversampling UART receiver.
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Default frame geometry: 8 payload bits, 16 clocks per bit
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  // Majority of three samples; a single corrupted sample cannot flip the bit
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for an asynchronous single-bit input.
// The reset value is a parameter so an idle-high serial line resets to its idle level.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw input through the chain; preset to the idle level on reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver running at 16x the baud rate (one clock per oversample).
// Each bit is decided by a 3-sample majority around mid-bit; received bytes are
// offered on a valid/ready handshake with framing and overrun error pulses.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  // Mid-bit point and counter/index widths
  localparam int H  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Sample positions within a bit: two early samples, then the decision sample
  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  rx_state_e            r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic                 r_s0;
  logic                 r_s1;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_oerr;

  logic w_rxs;
  logic w_maj;
  logic w_dec;
  logic w_cnt_last;
  logic w_xfer;

  // Bring the asynchronous line into the clock domain, idling high
  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rxd),
    .o_q (w_rxs)
  );

  // The decision uses the two stored samples plus the live synchronized sample
  assign w_maj      = maj3(r_s0, r_s1, w_rxs);
  assign w_dec      = (r_cnt == CNT_DEC);
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_xfer     = r_valid & rx_ready;

  // Receiver FSM: bit timing, sample capture, shift register and output handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      // Error flags are single-cycle pulses
      r_ferr <= 1'b0;
      r_oerr <= 1'b0;

      // A completed transfer empties the holding register unless refilled below
      if (w_xfer) begin
        r_valid <= 1'b0;
      end

      // Capture the two samples that precede the decision point
      if (r_cnt == CNT_S0) begin
        r_s0 <= w_rxs;
      end
      if (r_cnt == CNT_S1) begin
        r_s1 <= w_rxs;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (!w_rxs) begin
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (w_dec && w_maj) begin
            // Line was high again at mid-bit: a glitch, not a start bit
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_cnt_last) begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
            r_idx   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (w_dec) begin
            r_shift[r_idx] <= w_maj;
          end
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (r_idx == IDX_LAST) begin
              r_state <= ST_STOP;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_STOP: begin
          if (w_dec) begin
            // Leave at mid-stop so the next start edge is caught promptly
            r_cnt <= '0;
            if (w_maj) begin
              r_state <= ST_IDLE;
              if (!r_valid || w_xfer) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                // Consumer still holds the previous byte: keep it, drop this one
                r_oerr <= 1'b1;
              end
            end else begin
              r_ferr  <= 1'b1;
              r_state <= ST_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_BREAK: begin
          // A held-low line must return high before a new start is accepted
          r_cnt <= '0;
          if (w_rxs) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_ferr;
  assign overrun_err = r_oerr;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- 8N1 UART receiver clocked directly by the 1.843200 MHz PLL output (outclk_0), so one clock equals one 16x oversample at 115200 baud.
- Recovers bytes from the asynchronous serial input pin using 3-sample majority voting at mid-bit.
- Presents each byte on a valid/ready handshake to downstream logic, with framing and overrun error flags.

Parameters:
- DATA_BITS, 8, payload bits per frame, sent LSB first.
- OVERSAMPLE, 16, clocks per bit; must be even and at least 8.
- SYNC_STAGES, 2, flip-flop stages in the rxd synchronizer; must be at least 2.

Ports:
- clk  input  1  receiver clock, fed from PLL outclk_0 (1.843200 MHz).
- rst  input  1  synchronous, active-low reset.
- rxd  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  received byte; valid only while rx_valid=1.
- rx_valid  output  1  a byte is held for the consumer.
- rx_ready  input  1  consumer accepts the held byte when rx_valid=1 and rx_ready=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun_err  output  1  one-cycle pulse: a byte completed while the previous byte was still unconsumed.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - all outputs low; rx_data=0; FSM in IDLE; counters 0.
  - synchronizer flops preset to 1 so no false start is detected.
  - reset mid-frame abandons the frame and delivers nothing.
- Synchronizer: rxd passes through SYNC_STAGES flops; rxs is the last stage. All logic below uses rxs.
- Sample counter: cnt counts 0..OVERSAMPLE-1 within each bit.
  - Samples are taken at cnt = H-1, H, H+1, where H = OVERSAMPLE/2.
  - The bit value is the majority of the three, decided at cnt = H+1.
- States:
  - IDLE: when rxs=0, go to START with cnt=0. That cycle is t0.
  - START: at the decision point, majority=1 means a false start; go to IDLE with no error. Majority=0 continues. At cnt=OVERSAMPLE-1, go to DATA with bit index 0.
  - DATA: at the decision point, shift the majority into bit[index] (LSB first). After bit DATA_BITS-1 reaches cnt=OVERSAMPLE-1, go to STOP.
  - STOP, at the decision point:
    - majority=1: deliver the byte (see handshake) and go to IDLE immediately. A new start edge can be caught from the second half of the stop bit.
    - majority=0: pulse frame_err, deliver nothing, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. This stops a held-low line from re-triggering START.
- Latency: rx_valid rises at t0 + (1+DATA_BITS)*OVERSAMPLE + H + 2 = t0+154 at the defaults.
- Handshake:
  - rx_valid stays high and rx_data stays stable until the transfer cycle (rx_valid=1 and rx_ready=1). rx_valid falls on the next edge.
  - rx_ready while rx_valid=0 is ignored.
- Delivery rules:
  - rx_valid=0: load rx_data and set rx_valid.
  - rx_valid=1 and transfer in the same cycle: load the new byte and keep rx_valid=1. No overrun.
  - rx_valid=1 with no transfer: the new byte is dropped, the old one is kept, and overrun_err pulses for one cycle.
- frame_err and overrun_err never assert in the same cycle; a frame error means no byte is delivered.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - the default constants DATA_BITS=8 and OVERSAMPLE=16;
  - the function maj3.
- One natural sub-module: sync_ff, a SYNC_STAGES-deep synchronizer with a parameterized reset value of 1.
- The counter, FSM and output register stay in uart_rx_os16.

Test Plan:
1. Send byte 0x55 at 16 clocks/bit with rx_ready=1 -> rx_valid pulses for one cycle at t0+154 with rx_data=0x55; frame_err=0, overrun_err=0.
2. Send 0xA3 with rx_ready=0, then 0x0F back-to-back -> rx_data stays 0xA3 and rx_valid stays 1; overrun_err pulses once at the second frame's delivery point.
3. Send 0x3C with the stop bit forced low and the line held low 40 more bits, then released -> frame_err pulses once; rx_valid stays 0; busy stays 1 until rxs returns high. The next frame 0x81 is received correctly.
4. Send a 4-clock low glitch on an idle line -> START aborts at cnt=H+1, busy drops, and no valid or error pulse occurs.
5. Inject a single-clock inverted sample at cnt=H of each data bit of 0xC6 -> majority vote still yields rx_data=0xC6.
6. Assert rst=0 for one cycle mid-DATA, then send 0x7E -> all outputs reset on the next edge; the aborted frame is not delivered, and 0x7E is received correctly with rx_valid at t0+154.
